// File: rtl/adpll_cfg_master_pkg.sv
// Shared definitions for the ADPLL configuration master: controller states,
// core parameter select codes and the number of boot-loaded parameters.
package adpll_cfg_master_pkg;

  // ST_RST is the parking state while reset is held; the first clock after
  // release moves to ST_CLR so the clear pulse lines up with that edge.
  typedef enum logic [2:0] {
    ST_RST,
    ST_CLR,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_IDLE,
    ST_RD_SETTLE,
    ST_RD_CAP
  } state_t;

  localparam logic [2:0] PSEL_NDIV   = 3'd0;
  localparam logic [2:0] PSEL_ALPHA  = 3'd1;
  localparam logic [2:0] PSEL_BETA   = 3'd2;
  localparam logic [2:0] PSEL_OFFSET = 3'd3;
  localparam logic [2:0] PSEL_THRESH = 3'd4;
  localparam logic [2:0] PSEL_KDCO   = 3'd5;

  localparam int NUM_PARAMS = 6;

endpackage

// File: rtl/adpll_cfg_master.sv
// Initiator for the ADPLL core programming/readback port. After reset it
// clears the core, boot-loads all six loop parameters from defaults, then
// serves host write and read commands over a valid/ready handshake.
module adpll_cfg_master
  import adpll_cfg_master_pkg::*;
#(
  parameter logic [3:0] NDIV_INIT   = 4'd2,
  parameter logic [4:0] ALPHA_INIT  = 5'd1,
  parameter logic [4:0] BETA_INIT   = 5'd2,
  parameter logic [4:0] OFFSET_INIT = 5'd0,
  parameter logic [4:0] THRESH_INIT = 5'd8,
  parameter logic [4:0] KDCO_INIT   = 5'd1,
  parameter int         SETTLE      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [2:0] cmd_sel,
  input  logic [4:0] cmd_value,
  output logic       cmd_err,
  output logic       rd_valid,
  output logic [5:0] rd_data,
  output logic       boot_done,
  output logic       clr,
  output logic       pgm,
  output logic [2:0] param_sel,
  output logic [4:0] pgm_value,
  output logic       out_sel,
  input  logic       sign,
  input  logic [4:0] dout
);

  localparam logic [2:0] LAST_IDX    = 3'(NUM_PARAMS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic       w_accept;
  logic       w_badWrite;
  logic [2:0] r_idx;
  logic       r_booting;
  logic [3:0] r_cnt;
  logic       r_cmdReady;
  logic       r_cmdErr;
  logic       r_rdValid;
  logic [5:0] r_rdData;
  logic       r_bootDone;
  logic       r_clr;
  logic       r_pgm;
  logic [2:0] r_paramSel;
  logic [4:0] r_pgmValue;
  logic       r_outSel;

  // Boot default table; the select code equals the boot index.
  function automatic logic [4:0] bootValue(input logic [2:0] idx);
    case (idx)
      PSEL_NDIV:   bootValue = {1'b0, NDIV_INIT};
      PSEL_ALPHA:  bootValue = ALPHA_INIT;
      PSEL_BETA:   bootValue = BETA_INIT;
      PSEL_OFFSET: bootValue = OFFSET_INIT;
      PSEL_THRESH: bootValue = THRESH_INIT;
      PSEL_KDCO:   bootValue = KDCO_INIT;
      default:     bootValue = 5'd0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RST;
    else     r_state <= w_nextState;
  end

  // Next-state logic, command acceptance and illegal-write detection.
  always_comb begin
    w_nextState = r_state;
    w_accept    = (r_state == ST_IDLE) && r_cmdReady && cmd_valid;
    w_badWrite  = 1'b0;
    case (r_state)
      ST_RST:    w_nextState = ST_CLR;
      ST_CLR:    w_nextState = ST_SETUP;
      ST_SETUP:  w_nextState = ST_STROBE;
      ST_STROBE: w_nextState = ST_HOLD;
      ST_HOLD: begin
        if (r_booting && (r_idx != LAST_IDX)) w_nextState = ST_SETUP;
        else                                  w_nextState = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_accept) begin
          if (cmd_op)                      w_nextState = ST_RD_SETTLE;
          else if (cmd_sel <= PSEL_KDCO)   w_nextState = ST_SETUP;
          else                             w_badWrite  = 1'b1;
        end
      end
      ST_RD_SETTLE: if (r_cnt == 4'd0) w_nextState = ST_RD_CAP;
      ST_RD_CAP:    w_nextState = ST_IDLE;
      default:      w_nextState = ST_RST;
    endcase
  end

  // Registered outputs and datapath, all derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= 3'd0;
      r_booting  <= 1'b0;
      r_cnt      <= 4'd0;
      r_cmdReady <= 1'b0;
      r_cmdErr   <= 1'b0;
      r_rdValid  <= 1'b0;
      r_rdData   <= 6'd0;
      r_bootDone <= 1'b0;
      r_clr      <= 1'b0;
      r_pgm      <= 1'b0;
      r_paramSel <= 3'd0;
      r_pgmValue <= 5'd0;
      r_outSel   <= 1'b0;
    end else begin
      r_clr      <= (w_nextState == ST_CLR);
      r_pgm      <= (w_nextState == ST_STROBE);
      r_cmdReady <= (w_nextState == ST_IDLE);
      r_cmdErr   <= w_badWrite;
      r_rdValid  <= (r_state == ST_RD_CAP);
      case (r_state)
        ST_CLR: begin
          r_booting  <= 1'b1;
          r_idx      <= 3'd0;
          r_paramSel <= 3'd0;
          r_pgmValue <= bootValue(3'd0);
        end
        ST_HOLD: begin
          if (w_nextState == ST_SETUP) begin
            r_idx      <= r_idx + 3'd1;
            r_paramSel <= r_idx + 3'd1;
            r_pgmValue <= bootValue(r_idx + 3'd1);
          end else if (r_booting) begin
            r_booting  <= 1'b0;
            r_bootDone <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_accept && cmd_op) begin
            r_outSel <= cmd_sel[0];
            r_cnt    <= SETTLE_LAST;
          end else if (w_nextState == ST_SETUP) begin
            r_paramSel <= cmd_sel;
            r_pgmValue <= cmd_value;
          end
        end
        ST_RD_SETTLE: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        ST_RD_CAP:    r_rdData <= {sign, dout};
        default: ;
      endcase
    end
  end

  assign cmd_ready = r_cmdReady;
  assign cmd_err   = r_cmdErr;
  assign rd_valid  = r_rdValid;
  assign rd_data   = r_rdData;
  assign boot_done = r_bootDone;
  assign clr       = r_clr;
  assign pgm       = r_pgm;
  assign param_sel = r_paramSel;
  assign pgm_value = r_pgmValue;
  assign out_sel   = r_outSel;

endmodule

// File: tb/tb_adpll_cfg_master.sv
// Bench for adpll_cfg_master: emulates the core's config registers and
// readback mux, runs boot, directed and random host commands, and resets
// mid-read and mid-boot.
module tb_adpll_cfg_master;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [2:0] cmd_sel;
  logic [4:0] cmd_value;
  logic       cmd_err;
  logic       rd_valid;
  logic [5:0] rd_data;
  logic       boot_done;
  logic       clr;
  logic       pgm;
  logic [2:0] param_sel;
  logic [4:0] pgm_value;
  logic       out_sel;
  logic       sign;
  logic [4:0] dout;

  logic [5:0] filtVal;
  logic [5:0] integVal;
  logic [4:0] coreRegs [6];
  logic [4:0] expRegs  [6];
  logic [4:0] defaults [6];
  logic       expOutSel;
  logic [2:0] expLastSel;
  logic [4:0] expLastVal;
  logic       prevPgm;
  int         violations;
  int         rdValidCount;
  int         errCount;
  int         checkCount;
  int         passCount;

  adpll_cfg_master #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_value(cmd_value), .cmd_err(cmd_err),
    .rd_valid(rd_valid), .rd_data(rd_data), .boot_done(boot_done),
    .clr(clr), .pgm(pgm), .param_sel(param_sel), .pgm_value(pgm_value),
    .out_sel(out_sel), .sign(sign), .dout(dout)
  );

  always #5 clk = ~clk;

  // Core readback mux: filter word on out_sel=0, integrator word on 1.
  assign {sign, dout} = out_sel ? integVal : filtVal;

  // Core register emulation plus protocol monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 6; i++) coreRegs[i] = 5'd0;
    end else if (pgm && param_sel < 3'd6) begin
      coreRegs[param_sel] = pgm_value;
    end
    if (pgm && clr)     violations++;
    if (pgm && prevPgm) violations++;
    prevPgm = pgm;
    if (rd_valid) rdValidCount++;
    if (cmd_err)  errCount++;
  end

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic checkCore(input string tag);
    for (int i = 0; i < 6; i++) checkOutput(tag, coreRegs[i], expRegs[i]);
  endtask

  // Walks the 20 post-reset edges; optionally reasserts reset at abortEdge.
  task automatic runBoot(input int abortEdge);
    int k;
    logic expPgm;
    for (int n = 1; n <= 20; n++) begin
      stepClk();
      k = (n - 3) / 3;
      expPgm = (n >= 3) && ((n - 3) % 3 == 0) && (k <= 5);
      checkOutput("boot_clr", clr, n == 1);
      checkOutput("boot_pgm", pgm, expPgm);
      if (expPgm) begin
        checkOutput("boot_sel", param_sel, k);
        checkOutput("boot_val", pgm_value, defaults[k]);
      end
      checkOutput("boot_done", boot_done, n >= 20);
      checkOutput("boot_ready", cmd_ready, n >= 20);
      if (n == abortEdge) begin
        rst = 1'b1;
        stepClk();
        checkOutput("abort_pgm", pgm, 0);
        checkOutput("abort_outs", {cmd_ready, boot_done, clr, pgm, param_sel, pgm_value}, 0);
        return;
      end
    end
    expLastSel = 3'd5;
    expLastVal = defaults[5];
    expOutSel  = 1'b0;
  endtask

  // Issues one host command from IDLE and checks its full cycle-level response.
  task automatic applyStimulus(input logic op, input logic [2:0] sel, input logic [4:0] val);
    logic [5:0] expRd;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_value = val;
    checkOutput("idle_ready", cmd_ready, 1);
    stepClk();
    cmd_valid = 1'b0;
    if (op) begin
      expOutSel = sel[0];
      expRd = expOutSel ? integVal : filtVal;
      checkOutput("rd_accept_ready", cmd_ready, 0);
      checkOutput("rd_outsel", out_sel, expOutSel);
      for (int k = 1; k <= SETTLE; k++) begin
        stepClk();
        checkOutput("rd_settle_valid", rd_valid, 0);
      end
      stepClk();
      checkOutput("rd_valid", rd_valid, 1);
      checkOutput("rd_data", rd_data, expRd);
      checkOutput("rd_done_ready", cmd_ready, 1);
      stepClk();
      checkOutput("rd_valid_drop", rd_valid, 0);
      checkOutput("rd_data_hold", rd_data, expRd);
      checkOutput("rd_outsel_hold", out_sel, expOutSel);
    end else if (sel <= 3'd5) begin
      checkOutput("wr_accept_ready", cmd_ready, 0);
      checkOutput("wr_setup_pgm", pgm, 0);
      checkOutput("wr_setup_sel", param_sel, sel);
      stepClk();
      checkOutput("wr_strobe_pgm", pgm, 1);
      checkOutput("wr_strobe_sel", param_sel, sel);
      checkOutput("wr_strobe_val", pgm_value, val);
      stepClk();
      checkOutput("wr_hold_pgm", pgm, 0);
      checkOutput("wr_hold_val", pgm_value, val);
      stepClk();
      checkOutput("wr_done_ready", cmd_ready, 1);
      checkOutput("wr_idle_sel", {param_sel, pgm_value}, {sel, val});
      checkOutput("wr_outsel_keep", out_sel, expOutSel);
      expRegs[sel] = val;
      expLastSel = sel;
      expLastVal = val;
    end else begin
      checkOutput("err_pulse", cmd_err, 1);
      checkOutput("err_ready", cmd_ready, 1);
      checkOutput("err_pgm", pgm, 0);
      stepClk();
      checkOutput("err_drop", cmd_err, 0);
      checkOutput("err_keep_sel", {param_sel, pgm_value}, {expLastSel, expLastVal});
    end
  endtask

  initial begin
    int rdSnap;
    int errSnap;
    defaults[0] = 5'd2; defaults[1] = 5'd1; defaults[2] = 5'd2;
    defaults[3] = 5'd0; defaults[4] = 5'd8; defaults[5] = 5'd1;
    for (int i = 0; i < 6; i++) begin
      expRegs[i]  = defaults[i];
      coreRegs[i] = 5'h1f;
    end
    checkCount = 0; passCount = 0; violations = 0;
    rdValidCount = 0; errCount = 0; prevPgm = 1'b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_sel = 3'd0; cmd_value = 5'd0;
    filtVal = 6'b010110;
    integVal = 6'b101001;

    repeat (3) stepClk();
    checkOutput("reset_outs",
      {cmd_ready, cmd_err, rd_valid, rd_data, boot_done, clr, pgm, param_sel, pgm_value, out_sel}, 0);

    // Host holds a read of the integrator from reset; must wait for boot.
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_sel = 3'd1;
    rst = 1'b0;
    runBoot(0);
    checkCore("boot_core");
    applyStimulus(1'b1, 3'd1, 5'd0);

    applyStimulus(1'b0, 3'd2, 5'd17);
    checkOutput("core_beta", coreRegs[2], 17);
    applyStimulus(1'b0, 3'd6, 5'd9);
    applyStimulus(1'b0, 3'd7, 5'd3);
    checkCore("after_err_core");
    applyStimulus(1'b1, 3'd0, 5'd0);

    for (int t = 0; t < 24; t++) begin
      filtVal  = 6'($urandom);
      integVal = 6'($urandom);
      applyStimulus(1'($urandom), 3'($urandom_range(0, 7)), 5'($urandom));
    end
    checkCore("random_core");

    // Reset during a read's settle window: the read must vanish silently.
    rdSnap  = rdValidCount;
    errSnap = errCount;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_sel = 3'd1;
    stepClk();
    cmd_valid = 1'b0;
    rst = 1'b1;
    stepClk();
    checkOutput("midread_rst_outs", {rd_valid, cmd_ready, out_sel, boot_done}, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) expRegs[i] = defaults[i];
    runBoot(12);
    rst = 1'b0;
    runBoot(0);
    checkCore("reboot_core");
    checkOutput("no_rd_after_rst", rdValidCount, rdSnap);
    checkOutput("no_err_after_rst", errCount, errSnap);
    checkOutput("protocol_violations", violations, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/adpll_cfg_master.md
Name: adpll_cfg_master

Overview:
- Initiator side of the ADPLL core's programming and readback interface.
- After reset it pulses clr, then boot-loads all six loop parameters (ndiv, alpha, beta, dco_offset, dco_thresh, kdco) from elaboration-time defaults.
- It then serves host write/read commands over a valid/ready handshake.
- Writes use a setup/strobe/hold sequence on pgm/param_sel/pgm_value. Reads drive out_sel, wait a settle time, then capture {sign, dout}.

Parameters:
- NDIV_INIT, 4'd2, boot value for param_sel 0 (pgm_value[4] driven 0)
- ALPHA_INIT, 5'd1, boot value for param_sel 1
- BETA_INIT, 5'd2, boot value for param_sel 2
- OFFSET_INIT, 5'd0, boot value for param_sel 3
- THRESH_INIT, 5'd8, boot value for param_sel 4
- KDCO_INIT, 5'd1, boot value for param_sel 5
- SETTLE, 2, cycles out_sel is held before readback capture (legal range 1..15)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  high only in IDLE with boot_done=1
- cmd_op  in  1  0=write, 1=read
- cmd_sel  in  3  write: param_sel target; read: bit0 = out_sel value
- cmd_value  in  5  write data
- cmd_err  out  1  one-cycle pulse: write with cmd_sel 6 or 7 rejected
- rd_valid  out  1  one-cycle pulse: rd_data valid
- rd_data  out  6  captured {sign, dout}
- boot_done  out  1  high once the boot load completes; sticky until rst
- clr  out  1  clear to core config registers
- pgm  out  1  program strobe to core
- param_sel  out  3  parameter select to core
- pgm_value  out  5  parameter value to core
- out_sel  out  1  readback select to core (0=filter, 1=integrator)
- sign  in  1  core readback sign
- dout  in  5  core readback magnitude

Behaviour:
- All outputs are registered. While rst=1, every output is 0 (cmd_ready=0, clr=0, pgm=0, param_sel=0, pgm_value=0, out_sel=0, rd_data=0, boot_done=0).
- States: CLR, SETUP, STROBE, HOLD, IDLE, RD_SETTLE, RD_CAP. A 3-bit boot index (0..5) and a "booting" flag select the data source: default table or latched host command.
- First edge with rst=0: enter CLR; clr=1 for exactly one cycle.
- CLR -> SETUP with index 0.
- SETUP: param_sel/pgm_value driven, pgm=0.
- STROBE: pgm=1 for exactly one cycle; param_sel/pgm_value unchanged.
- HOLD: pgm=0; param_sel/pgm_value unchanged.
- HOLD while booting with index<5: index++, go to SETUP.
- HOLD while booting with index=5: go to IDLE, boot_done=1.
- Boot timing: six writes x 3 cycles. boot_done rises on the 20th edge after rst release.
- IDLE: cmd_ready=1. Acceptance = cmd_valid & cmd_ready at an edge. Command fields are latched on acceptance; cmd_ready drops on the same edge.
- Write, cmd_sel<=5: go to SETUP. pgm is high in the 2nd cycle after the accept edge. Return to IDLE after HOLD, so one write every 4 cycles at best.
- Write, cmd_sel 6/7: stay in IDLE, cmd_err=1 for one cycle, no pgm activity, cmd_ready stays 1.
- Read: out_sel <= cmd_sel[0] on the accept edge; go to RD_SETTLE for SETTLE cycles (down-counter).
- RD_CAP: rd_data <= {sign, dout}, rd_valid=1 for one cycle, then IDLE.
- out_sel persists after a read; only a later read or rst changes it. rd_data holds until the next capture.
- param_sel/pgm_value hold their last driven values in IDLE.
- pgm is never high in any state other than STROBE. pgm and clr are never high together.
- rst mid-sequence (including mid-STROBE): pgm falls on that edge. The full clr + boot sequence reruns after release. Any in-flight host command is discarded with no rd_valid and no cmd_err.
- cmd_valid during boot: ignored (cmd_ready=0). The host must keep it asserted.

Decomposition:
- Shared package: state enum; param_sel codes PSEL_NDIV=0, PSEL_ALPHA=1, PSEL_BETA=2, PSEL_OFFSET=3, PSEL_THRESH=4, PSEL_KDCO=5; constant NUM_PARAMS=6.
- Single module; the boot default table is a small combinational function of the index. No sub-module needed.

Test Plan:
- Reset release, no commands -> clr=1 for 1 cycle on edge 1; six pgm pulses with (sel,value) = (0,2),(1,1),(2,2),(3,0),(4,8),(5,1), each one cycle and 3 cycles apart; boot_done=1 on edge 20; adpll_top registers match.
- Host write op=0, sel=2, value=5'd17 -> pgm high in 2nd cycle after accept with param_sel=2, pgm_value=17; core beta=17; cmd_ready back to 1 after 4 cycles.
- Host write sel=6 -> cmd_err pulse, no pgm, core registers unchanged.
- Read op=1, sel=1 with core integ={1,5'd9} -> out_sel=1; rd_valid after SETTLE+1 cycles; rd_data=6'b101001.
- cmd_valid held high from reset -> not accepted before boot_done; accepted on the first IDLE edge.
- rst asserted during the STROBE of boot index 3 -> pgm=0 on that edge; after release, clr pulses and the boot reruns from index 0.
